time_reg_ctrl: RTL

Timekeeping controller that owns the clock's BCD time registers and the digit colour offset, and arbitrates every update source into them: the internal one-second prescaler, the three debounced adjust pulses, and register writes/reads decoded from the SPI command processor. It sits between `cmdProc`/`button_pulse` and the digit renderer, replacing ad-hoc counter logic with one sequenced, hazard-free update per cycle.

---
 rtl/time_reg_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/time_reg_ctrl.sv
// BCD time/colour register block: one update class per cycle (write > adjust > tick), reads in parallel.
// All outputs registered; updates and read data appear 1 cycle after the strobe or terminal count.
module time_reg_ctrl #(
    parameter int TICKS_PER_SEC = 31_500_000,
    parameter int PRESC_W       = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       adj_sec_pulse,
    input  logic       adj_min_pulse,
    input  logic       adj_hrs_pulse,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [3:0] sec_u,
    output logic [2:0] sec_d,
    output logic [3:0] min_u,
    output logic [2:0] min_d,
    output logic [3:0] hrs_u,
    output logic [1:0] hrs_d,
    output logic [3:0] color_offset,
    output logic       sec_tick
);

    localparam logic [7:0] ADDR_SEC    = 8'h00;
    localparam logic [7:0] ADDR_MIN    = 8'h01;
    localparam logic [7:0] ADDR_HRS    = 8'h02;
    localparam logic [7:0] ADDR_CTRL   = 8'h03;
    localparam logic [7:0] ADDR_COLOR  = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h05;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               r_run;
    logic               r_wr_err;
    logic               r_tick_pending;

    logic       w_tc;
    logic       w_adj;
    logic       w_tick_apply;
    logic       w_bcd60_ok;
    logic       w_hrs_ok;
    logic       w_wr_reject;
    logic       w_sec_wr_ok;
    logic       w_presc_clr;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic [7:0] w_rd_mux;

    // Increment a 00..59 BCD field, wrapping 59 -> 00.
    function automatic logic [6:0] f_inc60(input logic [2:0] d, input logic [3:0] u);
        logic [6:0] res;
        if (d == 3'd5 && u == 4'd9) begin
            res = 7'h00;
        end else if (u == 4'd9) begin
            res = {d + 3'd1, 4'd0};
        end else begin
            res = {d, u + 4'd1};
        end
        return res;
    endfunction

    // Increment a 00..23 BCD hour, wrapping 23 -> 00.
    function automatic logic [5:0] f_inc24(input logic [1:0] d, input logic [3:0] u);
        logic [5:0] res;
        if (d == 2'd2 && u == 4'd3) begin
            res = 6'h00;
        end else if (u == 4'd9) begin
            res = {d + 2'd1, 4'd0};
        end else begin
            res = {d, u + 4'd1};
        end
        return res;
    endfunction

    assign w_tc         = r_run && (r_presc == PRESC_LAST);
    assign w_adj        = adj_sec_pulse || adj_min_pulse || adj_hrs_pulse;
    // A tick (fresh or deferred) only lands on a cycle free of writes and adjusts.
    assign w_tick_apply = !cmd_write && !w_adj && (w_tc || r_tick_pending);

    assign w_bcd60_ok  = (cmd_wdata[6:4] <= 3'd5) && (cmd_wdata[3:0] <= 4'd9);
    assign w_hrs_ok    = (cmd_wdata <= 8'h23) && (cmd_wdata[3:0] <= 4'd9);
    assign w_wr_reject = cmd_write &&
                         ((((cmd_addr == ADDR_SEC) || (cmd_addr == ADDR_MIN)) && !w_bcd60_ok) ||
                          ((cmd_addr == ADDR_HRS) && !w_hrs_ok));
    assign w_sec_wr_ok = cmd_write && (cmd_addr == ADDR_SEC) && w_bcd60_ok;
    assign w_presc_clr = w_sec_wr_ok ||
                         (cmd_write && (cmd_addr == ADDR_CTRL) && cmd_wdata[1]);

    assign w_sec_wrap = (sec_d == 3'd5) && (sec_u == 4'd9);
    assign w_min_wrap = (min_d == 3'd5) && (min_u == 4'd9);

    always_comb begin
        w_rd_mux = 8'h00;
        case (cmd_addr)
            ADDR_SEC:    w_rd_mux = {1'b0, sec_d, sec_u};
            ADDR_MIN:    w_rd_mux = {1'b0, min_d, min_u};
            ADDR_HRS:    w_rd_mux = {2'b00, hrs_d, hrs_u};
            ADDR_CTRL:   w_rd_mux = {7'd0, r_run};
            ADDR_COLOR:  w_rd_mux = {4'd0, color_offset};
            ADDR_STATUS: w_rd_mux = {6'd0, r_wr_err, r_run};
            default:     w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc        <= '0;
            r_run          <= 1'b1;
            r_wr_err       <= 1'b0;
            r_tick_pending <= 1'b0;
            rd_data        <= 8'h00;
            rd_valid       <= 1'b0;
            sec_u          <= 4'd0;
            sec_d          <= 3'd0;
            min_u          <= 4'd0;
            min_d          <= 3'd0;
            hrs_u          <= 4'd0;
            hrs_d          <= 2'd0;
            color_offset   <= 4'd0;
            sec_tick       <= 1'b0;
        end else begin
            rd_valid <= cmd_read;
            if (cmd_read) begin
                rd_data <= w_rd_mux;
            end

            sec_tick <= w_tick_apply;

            // Deferral never touches the prescaler, so tick phase is preserved.
            if (w_presc_clr) begin
                r_presc <= '0;
            end else if (r_run) begin
                r_presc <= w_tc ? '0 : r_presc + 1'b1;
            end

            if (w_presc_clr || w_tick_apply) begin
                r_tick_pending <= 1'b0;
            end else if (w_tc) begin
                r_tick_pending <= 1'b1;
            end

            // A same-cycle STATUS read saw the old flag; a new error must survive it.
            if (w_wr_reject) begin
                r_wr_err <= 1'b1;
            end else if (cmd_read && (cmd_addr == ADDR_STATUS)) begin
                r_wr_err <= 1'b0;
            end

            if (cmd_write) begin
                case (cmd_addr)
                    ADDR_SEC: begin
                        if (w_bcd60_ok) begin
                            {sec_d, sec_u} <= cmd_wdata[6:0];
                        end
                    end
                    ADDR_MIN: begin
                        if (w_bcd60_ok) begin
                            {min_d, min_u} <= cmd_wdata[6:0];
                        end
                    end
                    ADDR_HRS: begin
                        if (w_hrs_ok) begin
                            {hrs_d, hrs_u} <= cmd_wdata[5:0];
                        end
                    end
                    ADDR_CTRL:  r_run        <= cmd_wdata[0];
                    ADDR_COLOR: color_offset <= cmd_wdata[3:0];
                    default: ;
                endcase
            end else if (w_adj) begin
                if (adj_sec_pulse) begin
                    {sec_d, sec_u} <= f_inc60(sec_d, sec_u);
                end
                if (adj_min_pulse) begin
                    {min_d, min_u} <= f_inc60(min_d, min_u);
                    color_offset   <= color_offset + 4'd1;
                end
                if (adj_hrs_pulse) begin
                    {hrs_d, hrs_u} <= f_inc24(hrs_d, hrs_u);
                end
            end else if (w_tick_apply) begin
                {sec_d, sec_u} <= f_inc60(sec_d, sec_u);
                if (w_sec_wrap) begin
                    {min_d, min_u} <= f_inc60(min_d, min_u);
                    color_offset   <= color_offset + 4'd1;
                    if (w_min_wrap) begin
                        {hrs_d, hrs_u} <= f_inc24(hrs_d, hrs_u);
                    end
                end
            end
        end
    end

endmodule
